// File: rtl/mbist_pkg.sv
// March C- BIST shared types: FSM states, element encoding,
// per-element direction and data-pattern helpers.
package mbist_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  typedef enum logic [2:0] {
    E_W0    = 3'd0,
    E_R0W1  = 3'd1,
    E_R1W0  = 3'd2,
    E_DR0W1 = 3'd3,
    E_DR1W0 = 3'd4,
    E_R0    = 3'd5
  } elem_e;

  // Single-bit patterns, replicated to the data width.
  localparam logic PAT0 = 1'b0;
  localparam logic PAT1 = 1'b1;

  function automatic logic el_down(elem_e e);
    return (e == E_DR0W1) || (e == E_DR1W0);
  endfunction

  function automatic logic el_rpat(elem_e e);
    return ((e == E_R1W0) || (e == E_DR1W0)) ? PAT1 : PAT0;
  endfunction

  function automatic logic el_wpat(elem_e e);
    return ((e == E_R0W1) || (e == E_DR0W1)) ? PAT1 : PAT0;
  endfunction

endpackage

// File: rtl/mbist_addr_gen.sv
// Up/down address counter with terminal-count flag.
// load_i/load_down_i: preset to 0 or max; step_i/down_i: count; tc_o: last address.
module mbist_addr_gen #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              load_down_i,
  input  logic              step_i,
  input  logic              down_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              tc_o
);

  logic [ADDR_W-1:0] addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
    end else if (load_i) begin
      addr_q <= load_down_i ? '1 : '0;
    end else if (step_i) begin
      addr_q <= down_i ? addr_q - ADDR_W'(1)
                       : addr_q + ADDR_W'(1);
    end
  end

  assign addr_o = addr_q;
  assign tc_o   = down_i ? (addr_q == '0) : (addr_q == '1);

endmodule

// File: rtl/mbist_march_ctrl.sv
// March C- memory BIST controller with first-failure capture.
// Drives mem_addr/mem_wdata/mem_wr, checks mem_rdata; reports busy/done/fail/fail_*.
module mbist_march_ctrl
  import mbist_pkg::*;
#(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 8,
  parameter bit STOP_ON_FAIL = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_elem,
  output logic [DATA_W-1:0] fail_data
);

  state_e            state_q;
  elem_e             elem_q;
  logic              wr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              fail_q;
  logic [ADDR_W-1:0] faddr_q;
  logic [2:0]        felem_q;
  logic [DATA_W-1:0] fdata_q;

  logic  go, run, mis, stop;
  logic  last_op, last_el, adv;
  logic  tc, ld, ld_down, step;
  elem_e elem_nx, elem_at;

  assign go   = start && (state_q != RUN);
  assign run  = state_q == RUN;
  // mem_wr doubles as the read/write phase of the current op.
  assign mis  = run && !wr_q &&
                (mem_rdata != {DATA_W{el_rpat(elem_q)}});
  assign stop = STOP_ON_FAIL && mis;

  // Element 0 is write-only and element 5 read-only.
  assign last_op = wr_q || (elem_q == E_R0);
  assign last_el = elem_q == E_R0;
  assign adv     = run && last_op && !stop;
  assign elem_nx = elem_e'(elem_q + 3'd1);
  assign elem_at = tc ? elem_nx : elem_q;

  assign ld      = go || (adv && tc && !last_el);
  assign ld_down = go ? 1'b0 : el_down(elem_nx);
  assign step    = adv && !tc;

  mbist_addr_gen #(
    .ADDR_W(ADDR_W)
  ) u_agen (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (ld),
    .load_down_i(ld_down),
    .step_i     (step),
    .down_i     (el_down(elem_q)),
    .addr_o     (mem_addr),
    .tc_o       (tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      elem_q  <= E_W0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      fail_q  <= 1'b0;
      faddr_q <= '0;
      felem_q <= '0;
      fdata_q <= '0;
    end else if (go) begin
      state_q <= RUN;
      elem_q  <= E_W0;
      wr_q    <= 1'b1;
      wdata_q <= {DATA_W{PAT0}};
      fail_q  <= 1'b0;
      faddr_q <= '0;
      felem_q <= '0;
      fdata_q <= '0;
    end else if (run) begin
      if (mis && !fail_q) begin
        fail_q  <= 1'b1;
        faddr_q <= mem_addr;
        felem_q <= elem_q;
        fdata_q <= mem_rdata;
      end
      if (stop || (adv && tc && last_el)) begin
        state_q <= DONE;
        wr_q    <= 1'b0;
      end else if (adv) begin
        // New address: only element 0 starts with a write.
        if (tc) elem_q <= elem_nx;
        wr_q <= elem_at == E_W0;
        if (elem_at == E_W0) begin
          wdata_q <= {DATA_W{el_wpat(elem_at)}};
        end
      end else begin
        wr_q    <= 1'b1;
        wdata_q <= {DATA_W{el_wpat(elem_q)}};
      end
    end
  end

  assign mem_wr    = wr_q;
  assign mem_wdata = wdata_q;
  assign busy      = state_q == RUN;
  assign done      = state_q == DONE;
  assign fail      = fail_q;
  assign fail_addr = faddr_q;
  assign fail_elem = felem_q;
  assign fail_data = fdata_q;

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Scoreboard bench for mbist_march_ctrl: fault-free, stuck-at,
// decoder-fault, stop-on-fail, restart and async-reset scenarios.
module tb_mbist_march_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic start_s = 1'b0;

  always #5 clk = ~clk;

  logic [7:0] addr, wdata, rdata, fa, fd;
  logic       wr, busy, done, fail;
  logic [2:0] fe;
  logic [7:0] addr_s, wdata_s, rdata_s, fa_s, fd_s;
  logic       wr_s, busy_s, done_s, fail_s;
  logic [2:0] fe_s;

  mbist_march_ctrl #(.ADDR_W(8), .DATA_W(8), .STOP_ON_FAIL(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .mem_addr(addr), .mem_wdata(wdata), .mem_wr(wr),
    .mem_rdata(rdata), .busy(busy), .done(done), .fail(fail),
    .fail_addr(fa), .fail_elem(fe), .fail_data(fd)
  );

  mbist_march_ctrl #(.ADDR_W(8), .DATA_W(8), .STOP_ON_FAIL(1'b1)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start_s),
    .mem_addr(addr_s), .mem_wdata(wdata_s), .mem_wr(wr_s),
    .mem_rdata(rdata_s), .busy(busy_s), .done(done_s), .fail(fail_s),
    .fail_addr(fa_s), .fail_elem(fe_s), .fail_data(fd_s)
  );

  // RAM models: fault 1 = bit 3 stuck-at-0 at 0x5A,
  // fault 2 = a write to 0x10 also writes 0x11.
  logic [7:0] mem [256];
  logic [7:0] mem_s [256];
  int fault = 0;

  always @(posedge clk) begin
    if (wr) begin
      mem[addr] <= wdata;
      if (fault == 2 && addr == 8'h10) mem[8'h11] <= wdata;
    end
    if (wr_s) mem_s[addr_s] <= wdata_s;
  end

  assign rdata = (fault == 1 && addr == 8'h5A) ?
                 (mem[addr] & 8'hF7) : mem[addr];
  assign rdata_s = (addr_s == 8'h5A) ?
                   (mem_s[addr_s] & 8'hF7) : mem_s[addr_s];

  typedef struct {
    int         cyc;
    logic       f;
    logic [7:0] a;
    logic [2:0] e;
    logic [7:0] d;
  } exp_t;

  exp_t q[$];
  exp_t qs[$];
  exp_t em, ems;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  // Monitors: count busy cycles, compare on the rising edge of done.
  int   cnt = 0, cnt_s = 0;
  logic bp = 1'b0, dp = 1'b0, bps = 1'b0, dps = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      cnt = 0; bp = 1'b0; dp = 1'b0;
    end else begin
      if (busy) cnt = bp ? cnt + 1 : 1;
      if (done && !dp) begin
        if (q.size() == 0) chk("unexpected done", 1, 0);
        else begin
          em = q.pop_front();
          chk("run cycles", cnt, em.cyc);
          chk("fail", fail, em.f);
          chk("fail_addr", fa, em.a);
          chk("fail_elem", fe, em.e);
          chk("fail_data", fd, em.d);
        end
      end
      bp = busy; dp = done;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      cnt_s = 0; bps = 1'b0; dps = 1'b0;
    end else begin
      if (busy_s) cnt_s = bps ? cnt_s + 1 : 1;
      if (done_s && !dps) begin
        if (qs.size() == 0) chk("unexpected done_s", 1, 0);
        else begin
          ems = qs.pop_front();
          chk("stop run cycles", cnt_s, ems.cyc);
          chk("stop fail", fail_s, ems.f);
          chk("stop fail_addr", fa_s, ems.a);
          chk("stop fail_elem", fe_s, ems.e);
          chk("stop fail_data", fd_s, ems.d);
        end
      end
      bps = busy_s; dps = done_s;
    end
  end

  task automatic pulse(input bit s);
    @(posedge clk); #1;
    if (s) start_s = 1'b1; else start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    start_s = 1'b0;
  endtask

  task automatic wait_done(input bit s, input int lim);
    int n = 0;
    while (!(s ? done_s : done) && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk(s ? "done_s seen" : "done seen", s ? done_s : done, 1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " addr"}, addr, 0);
    chk({tag, " wdata"}, wdata, 0);
    chk({tag, " wr"}, wr, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " done"}, done, 0);
    chk({tag, " fail"}, fail, 0);
    chk({tag, " fail_addr"}, fa, 0);
    chk({tag, " fail_elem"}, fe, 0);
    chk({tag, " fail_data"}, fd, 0);
  endtask

  initial begin
    int nz;
    int w;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle busy", busy, 0);

    // Fault-free run with a spurious start mid-run.
    fault = 0;
    pulse(0);
    q.push_back('{2560, 1'b0, 8'h00, 3'd0, 8'h00});
    chk("first addr", addr, 8'h00);
    chk("first wr", wr, 1);
    chk("first wdata", wdata, 8'h00);
    chk("first busy", busy, 1);
    repeat (300) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(0, 3000);
    chk("done busy", busy, 0);
    nz = 0;
    for (int i = 0; i < 256; i++) nz += (mem[i] !== 8'h00) ? 1 : 0;
    chk("ram all zero", nz, 0);

    // Stuck-at-0 bit 3 at 0x5A.
    fault = 1;
    pulse(0);
    q.push_back('{2560, 1'b1, 8'h5A, 3'd2, 8'hF7});
    wait_done(0, 3000);

    // Decoder fault; restart from DONE clears the capture.
    fault = 2;
    pulse(0);
    chk("restart fail", fail, 0);
    chk("restart fail_addr", fa, 0);
    chk("restart fail_elem", fe, 0);
    chk("restart fail_data", fd, 0);
    chk("restart busy", busy, 1);
    q.push_back('{2560, 1'b1, 8'h11, 3'd1, 8'hFF});
    wait_done(0, 3000);

    // Stop-on-fail with the stuck-at fault.
    pulse(1);
    qs.push_back('{949, 1'b1, 8'h5A, 3'd2, 8'hF7});
    wait_done(1, 3000);
    w = 0;
    repeat (20) begin
      @(negedge clk);
      w += wr_s ? 1 : 0;
    end
    chk("stop no writes", w, 0);
    chk("stop busy", busy_s, 0);

    // Asynchronous reset mid-run.
    fault = 0;
    pulse(0);
    repeat (1000) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_zero("async reset");
    chk("async reset done_s", done_s, 0);
    #4 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("post reset busy", busy, 0);
    chk("post reset done", done, 0);
    chk("post reset wr", wr, 0);
    chk("queues drained", q.size() + qs.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
